// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS/CTRL
// bit positions and the TX/RX state encodings.
package uart_pkg;

    localparam logic [3:0] AddrData   = 4'h0;
    localparam logic [3:0] AddrStatus = 4'h4;
    localparam logic [3:0] AddrCtrl   = 4'h8;
    localparam logic [3:0] AddrBaud   = 4'hC;

    localparam int unsigned StatRxNotEmpty = 0;
    localparam int unsigned StatRxFull     = 1;
    localparam int unsigned StatTxFull     = 2;
    localparam int unsigned StatTxEmpty    = 3;
    localparam int unsigned StatTxBusy     = 4;
    localparam int unsigned StatRxOverrun  = 5;
    localparam int unsigned StatRxFrameErr = 6;

    localparam int unsigned CtrlRxEn    = 0;
    localparam int unsigned CtrlTxEn    = 1;
    localparam int unsigned CtrlFlush   = 2;
    localparam int unsigned CtrlIrqRxEn = 3;
    localparam int unsigned CtrlIrqTxEn = 4;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush. A push and pop in the same cycle are both honoured;
// on an empty FIFO the pushed word falls straight through to rdata_o.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
    assign level_o = cnt_q;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~(empty_o & pop_i) & (~full_o | pop_i);
    assign rdata_o = empty_o ? (push_i ? wdata_i : '0) : mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            cnt_d = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_fifo.sv
// Memory-mapped UART: register block, baud timing, TX shifter and RX sampler
// around a pair of character FIFOs.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_uart,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [3:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        data_in_rx,
    output logic        data_out_tx,
    output logic        irq
);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

    logic                 wr, rd, flush;
    logic [3:0]           reg_addr;
    logic                 rx_en_q, rx_en_d, tx_en_q, tx_en_d;
    logic                 irq_rx_en_q, irq_rx_en_d, irq_tx_en_q, irq_tx_en_d;
    logic [DIV_W-1:0]     baud_q, baud_d, period, period_m1, half_m1;
    logic                 overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [31:0]          read_data_q, read_data_d, rd_mux, status;
    logic                 irq_q, irq_d;

    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_rdata;
    logic [LvlW-1:0]      tx_level;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] rx_rdata;
    logic [LvlW-1:0]      rx_level;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], write_data, tx_level, rx_level};

    assign wr       = sel_uart & mem_write;
    assign rd       = sel_uart & mem_read;
    assign reg_addr = {addr[3:2], 2'b00};
    assign flush    = wr && (reg_addr == AddrCtrl) && write_data[CtrlFlush];

    // Bit period never drops below two clocks so the half-period sample point exists.
    assign period    = (baud_q < DIV_W'(2)) ? DIV_W'(2) : baud_q;
    assign period_m1 = period - 1'b1;
    assign half_m1   = (period >> 1) - 1'b1;

    assign tx_push = wr && (reg_addr == AddrData);
    assign rx_pop  = rd && (reg_addr == AddrData);

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (tx_push),
        .wdata_i (write_data[DATA_BITS-1:0]),
        .pop_i   (tx_pop),
        .rdata_o (tx_rdata),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    // ---------------- TX ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BitW-1:0]      tx_bit_q, tx_bit_d;
    logic                 tx_tick;

    assign tx_tick = (tx_cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_pop     = 1'b0;
        if (flush) begin
            tx_state_d = TxIdle;
            tx_cnt_d   = '0;
        end else begin
            if (!tx_tick) tx_cnt_d = tx_cnt_q - 1'b1;
            unique case (tx_state_q)
                TxIdle: begin
                    if (tx_en_q && !tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_rdata;
                        tx_cnt_d   = period_m1;
                        tx_state_d = TxStart;
                    end
                end
                TxStart: begin
                    if (tx_tick) begin
                        tx_state_d = TxData;
                        tx_cnt_d   = period_m1;
                        tx_bit_d   = '0;
                    end
                end
                TxData: begin
                    if (tx_tick) begin
                        tx_cnt_d = period_m1;
                        if (tx_bit_q == BitW'(DATA_BITS - 1)) begin
                            tx_state_d = TxStop;
                        end else begin
                            tx_shift_d = tx_shift_q >> 1;
                            tx_bit_d   = tx_bit_q + 1'b1;
                        end
                    end
                end
                TxStop: begin
                    if (tx_tick) begin
                        if (tx_en_q && !tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_rdata;
                            tx_cnt_d   = period_m1;
                            tx_state_d = TxStart;
                        end else begin
                            tx_state_d = TxIdle;
                        end
                    end
                end
                default: tx_state_d = TxIdle;
            endcase
        end
    end

    always_comb begin
        data_out_tx = 1'b1;
        unique case (tx_state_q)
            TxStart: data_out_tx = 1'b0;
            TxData:  data_out_tx = tx_shift_q[0];
            default: data_out_tx = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_e            rx_state_q, rx_state_d;
    logic [DIV_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [BitW-1:0]      rx_bit_q, rx_bit_d;
    logic [2:0]           rx_sync_q;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_s, rx_fall, rx_tick, frame_set, overrun_set;

    // [0],[1] form the synchroniser; [2] is the previous synchronised value.
    assign rx_s    = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];
    assign rx_tick = (rx_cnt_q == '0);

    assign rx_push     = rx_done_q & (~rx_full | rx_pop);
    assign overrun_set = rx_done_q & rx_full & ~rx_pop;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (rx_push),
        .wdata_i (rx_shift_q),
        .pop_i   (rx_pop),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q  <= 3'b111;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[1:0], data_in_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_done_q  <= rx_done_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_done_d  = 1'b0;
        frame_set  = 1'b0;
        if (flush || !rx_en_q) begin
            rx_state_d = RxIdle;
            rx_cnt_d   = '0;
        end else begin
            if (!rx_tick) rx_cnt_d = rx_cnt_q - 1'b1;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rx_fall) begin
                        rx_state_d = RxStart;
                        rx_cnt_d   = half_m1;
                    end
                end
                RxStart: begin
                    if (rx_tick) begin
                        if (rx_s) begin
                            rx_state_d = RxIdle;
                        end else begin
                            rx_state_d = RxData;
                            rx_cnt_d   = period_m1;
                            rx_bit_d   = '0;
                        end
                    end
                end
                RxData: begin
                    if (rx_tick) begin
                        rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                        rx_cnt_d   = period_m1;
                        if (rx_bit_q == BitW'(DATA_BITS - 1)) rx_state_d = RxStop;
                        else rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_tick) begin
                        rx_state_d = RxIdle;
                        if (rx_s) rx_done_d = 1'b1;
                        else frame_set = 1'b1;
                    end
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    // ---------------- Registers ----------------
    always_comb begin
        rx_en_d     = rx_en_q;
        tx_en_d     = tx_en_q;
        irq_rx_en_d = irq_rx_en_q;
        irq_tx_en_d = irq_tx_en_q;
        baud_d      = baud_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (wr) begin
            case (reg_addr)
                AddrStatus: begin
                    if (write_data[StatRxOverrun])  overrun_d   = 1'b0;
                    if (write_data[StatRxFrameErr]) frame_err_d = 1'b0;
                end
                AddrCtrl: begin
                    rx_en_d     = write_data[CtrlRxEn];
                    tx_en_d     = write_data[CtrlTxEn];
                    irq_rx_en_d = write_data[CtrlIrqRxEn];
                    irq_tx_en_d = write_data[CtrlIrqTxEn];
                end
                AddrBaud: baud_d = write_data[DIV_W-1:0];
                default: ;
            endcase
        end
        if (overrun_set) overrun_d   = 1'b1;
        if (frame_set)   frame_err_d = 1'b1;
    end

    always_comb begin
        status                 = '0;
        status[StatRxNotEmpty] = ~rx_empty;
        status[StatRxFull]     = rx_full;
        status[StatTxFull]     = tx_full;
        status[StatTxEmpty]    = tx_empty;
        status[StatTxBusy]     = (tx_state_q != TxIdle);
        status[StatRxOverrun]  = overrun_q;
        status[StatRxFrameErr] = frame_err_q;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            AddrData:   rd_mux = 32'(rx_rdata);
            AddrStatus: rd_mux = status;
            AddrCtrl: begin
                rd_mux[CtrlRxEn]    = rx_en_q;
                rd_mux[CtrlTxEn]    = tx_en_q;
                rd_mux[CtrlIrqRxEn] = irq_rx_en_q;
                rd_mux[CtrlIrqTxEn] = irq_tx_en_q;
            end
            AddrBaud:   rd_mux = 32'(baud_q);
            default:    rd_mux = '0;
        endcase
        read_data_d = rd ? rd_mux : read_data_q;
        irq_d = (irq_rx_en_q & ~rx_empty) | (irq_tx_en_q & tx_empty) | overrun_q | frame_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_en_q     <= 1'b0;
            tx_en_q     <= 1'b0;
            irq_rx_en_q <= 1'b0;
            irq_tx_en_q <= 1'b0;
            baud_q      <= DIV_W'(DEFAULT_DIV);
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            read_data_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            rx_en_q     <= rx_en_d;
            tx_en_q     <= tx_en_d;
            irq_rx_en_q <= irq_rx_en_d;
            irq_tx_en_q <= irq_tx_en_d;
            baud_q      <= baud_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            read_data_q <= read_data_d;
            irq_q       <= irq_d;
        end
    end

    assign read_data = read_data_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed-plus-random bench for uart_fifo: bus accesses, serial line driving and a
// queue model of the characters expected back from the RX FIFO.
module tb_uart_fifo;
    localparam int unsigned Div = 16;

    logic        clk = 1'b0;
    logic        rst, sel_uart, mem_write, mem_read;
    logic [3:0]  addr;
    logic [31:0] write_data, read_data;
    logic        data_in_rx, data_out_tx, irq;
    logic        loop_en, rx_drv;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [7:0]  exp_q[$];

    assign data_in_rx = loop_en ? data_out_tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_W(16), .DEFAULT_DIV(868)) dut (
        .clk         (clk),
        .rst         (rst),
        .sel_uart    (sel_uart),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .addr        (addr),
        .write_data  (write_data),
        .read_data   (read_data),
        .data_in_rx  (data_in_rx),
        .data_out_tx (data_out_tx),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel_uart = 1'b1; mem_write = 1'b1; addr = a; write_data = d;
        @(negedge clk);
        sel_uart = 1'b0; mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel_uart = 1'b1; mem_read = 1'b1; addr = a;
        @(negedge clk);
        sel_uart = 1'b0; mem_read = 1'b0;
        d = read_data;
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic stop);
        logic [9:0] frame;
        frame = {stop, ch, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = frame[i];
            repeat (Div) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [9:0]  frame;
        logic [7:0]  ch;
        bit          found;
        int          lows;

        rst = 1'b1; sel_uart = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        addr = '0; write_data = '0; loop_en = 1'b0; rx_drv = 1'b1;
        idle(3);
        check("rst_tx_line", 32'(data_out_tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        rst = 1'b0;
        idle(1);
        bus_read(4'h4, v); check("reset_status", v, 32'h8);
        bus_read(4'hC, v); check("reset_baud", v, 32'd868);

        // Single TX character, bit-accurate line check
        bus_write(4'hC, Div);
        bus_write(4'h8, 32'h2);
        bus_write(4'h0, 32'h55);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (data_out_tx == 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        check("tx_start_seen", 32'(found), 32'd1);
        idle(7);
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), 32'(data_out_tx), 32'(frame[i]));
            if (i < 9) idle(Div);
        end
        bus_read(4'h4, v); check("tx_busy_status", v, 32'h18);
        idle(20);
        bus_read(4'h4, v); check("tx_done_status", v, 32'h08);

        // Loopback: fixed pair followed by random characters
        loop_en = 1'b1;
        bus_write(4'h8, 32'h3);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        foreach (exp_q[i]) bus_write(4'h0, 32'(exp_q[i]));
        idle(6 * 10 * Div + 100);
        while (exp_q.size() > 0) begin
            bus_read(4'h0, v);
            check("loop_rx_char", v, 32'(exp_q.pop_front()));
        end
        bus_read(4'h0, v); check("loop_empty_read", v, 32'd0);
        bus_read(4'h4, v); check("loop_status_empty", v, 32'h08);
        check("loop_irq_quiet", 32'(irq), 32'd0);

        // Overrun: one more character than the FIFO holds
        loop_en = 1'b0;
        bus_write(4'h8, 32'h1);
        for (int i = 0; i < 17; i++) begin
            ch = 8'($urandom_range(0, 255));
            if (exp_q.size() < 16) exp_q.push_back(ch);
            send_frame(ch, 1'b1);
        end
        idle(4);
        bus_read(4'h4, v); check("overrun_status", v, 32'h2B);
        idle(2);
        check("overrun_irq", 32'(irq), 32'd1);
        bus_write(4'h4, 32'h20);
        bus_read(4'h4, v); check("overrun_w1c", v, 32'h0B);
        idle(2);
        check("overrun_irq_cleared", 32'(irq), 32'd0);
        while (exp_q.size() > 0) begin
            bus_read(4'h0, v);
            check("overrun_kept_char", v, 32'(exp_q.pop_front()));
        end
        bus_read(4'h4, v); check("overrun_drained", v, 32'h08);

        // Framing error, then a short glitch that must be ignored
        send_frame(8'($urandom_range(0, 255)), 1'b0);
        idle(4);
        bus_read(4'h4, v); check("frame_err_status", v, 32'h48);
        check("frame_err_irq", 32'(irq), 32'd1);
        bus_write(4'h4, 32'h40);
        idle(2);
        check("frame_err_irq_cleared", 32'(irq), 32'd0);
        rx_drv = 1'b0;
        idle(4);
        rx_drv = 1'b1;
        idle(100);
        bus_read(4'h4, v); check("glitch_ignored", v, 32'h08);

        // RX and TX interrupt enables
        bus_write(4'h8, 32'h9);
        ch = 8'($urandom_range(0, 255));
        send_frame(ch, 1'b1);
        idle(4);
        check("irq_rx_level", 32'(irq), 32'd1);
        bus_read(4'h0, v); check("irq_rx_char", v, 32'(ch));
        idle(2);
        check("irq_rx_dropped", 32'(irq), 32'd0);
        bus_write(4'h8, 32'h10);
        idle(2);
        check("irq_tx_empty", 32'(irq), 32'd1);
        bus_write(4'h8, 32'h0);
        idle(2);
        check("irq_off", 32'(irq), 32'd0);

        // Flush in the middle of the second of three queued characters
        bus_write(4'h8, 32'h2);
        for (int i = 0; i < 3; i++) bus_write(4'h0, 32'($urandom_range(0, 255)));
        idle(240);
        bus_write(4'h8, 32'h6);
        check("flush_line_high", 32'(data_out_tx), 32'd1);
        bus_read(4'h4, v); check("flush_status", v, 32'h08);
        bus_read(4'h8, v); check("flush_ctrl_readback", v, 32'h02);
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (!data_out_tx) lows++;
        end
        check("flush_no_more_tx", 32'(lows), 32'd0);

        // Asynchronous reset in the middle of a character
        bus_write(4'h0, 32'h00);
        idle(40);
        check("pre_reset_line_low", 32'(data_out_tx), 32'd0);
        #2 rst = 1'b1;
        #1 check("async_rst_line", 32'(data_out_tx), 32'd1);
        check("async_rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(4'hC, v); check("post_rst_baud", v, 32'd868);
        bus_read(4'h8, v); check("post_rst_ctrl", v, 32'h0);
        bus_read(4'h4, v); check("post_rst_status", v, 32'h08);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Memory-mapped UART with parametrised character width, TX/RX FIFOs, programmable baud divisor, sticky error flags and a level interrupt. It replaces the single-byte UART register block at 0x80000000–0x8000000F. It is self-contained: baud timing, TX shifter, RX sampler and FIFOs are all inside. Bus side is the core's single-cycle store/load interface with a registered read.

Parameters:
DATA_BITS, 8, character width, legal 5..8, LSB first on the line
FIFO_DEPTH, 16, entries per FIFO, power of two, >=2
DIV_W, 16, width of the baud divisor register
DEFAULT_DIV, 868, reset value of BAUD_DIV in clocks per bit (100 MHz / 115200)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
sel_uart  in  1  address decode hit for the UART window
mem_write  in  1  store strobe, qualified by sel_uart
mem_read  in  1  load strobe, qualified by sel_uart
addr  in  4  byte offset in window, word-aligned; addr[1:0] ignored
write_data  in  32  store data
read_data  out  32  load data, registered
data_in_rx  in  1  serial input, asynchronous
data_out_tx  out  1  serial output
irq  out  1  level interrupt to core

Behaviour:
- Reset: read_data=0, data_out_tx=1, irq=0, FIFOs empty, CTRL=0, sticky flags=0, BAUD_DIV=DEFAULT_DIV, TX/RX FSMs IDLE.
- Register map:
  0x0 DATA: write pushes write_data[DATA_BITS-1:0] to TX FIFO; read pops RX FIFO, returns zero-extended char.
  0x4 STATUS: bit0 rx_not_empty, bit1 rx_full, bit2 tx_full, bit3 tx_empty, bit4 tx_busy, bit5 rx_overrun, bit6 rx_frame_err, others 0. Bits 5,6 are W1C; all other bits RO.
  0x8 CTRL (RW): bit0 rx_en, bit1 tx_en, bit2 flush (self-clearing, reads 0), bit3 irq_rx_en, bit4 irq_tx_en.
  0xC BAUD_DIV (RW): [DIV_W-1:0]; effective bit period = max(BAUD_DIV,2) clocks.
- Read latency 1 cycle: read_data updates on the edge after sel_uart&mem_read and holds until the next read. Pop happens on that same edge.
- Pop on empty RX FIFO returns 0, no state change. Push on full TX FIFO is dropped silently.
- Simultaneous push and pop on one FIFO in the same cycle: both performed, level unchanged, even when full/empty. This covers RX completion plus a DATA read.
- Flush: clears both FIFOs, aborts TX (line to 1 next cycle) and RX (to IDLE). CTRL bits other than flush take the written value.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Leaves IDLE when tx_en=1 and the FIFO is not empty; pops the char on that edge.
  - START: line=0. DATA: DATA_BITS bits. STOP: line=1. Each state lasts one bit period.
  - From STOP end, goes straight to START if more data is queued.
  - tx_busy = state!=IDLE. Clearing tx_en mid-character finishes the current character.
- RX path:
  - 2-flop synchroniser on data_in_rx, then FSM IDLE -> START -> DATA -> STOP.
  - Falling edge with rx_en=1 enters START. At half period, line high means false start: return to IDLE, nothing recorded.
  - Each data bit and the stop bit are sampled one full period apart, at bit centre.
  - Stop=0: frame_err set, char discarded.
  - Stop=1 with FIFO full: overrun set, char discarded.
  - Otherwise push on the edge after the stop sample.
  - Clearing rx_en aborts to IDLE.
- BAUD_DIV write mid-character takes effect at the next bit boundary.
- irq = (irq_rx_en & rx_not_empty) | (irq_tx_en & tx_empty) | rx_overrun | rx_frame_err, registered, 1-cycle lag.
- Async rst mid-operation returns everything to reset values immediately; data_out_tx=1 with no glitch low.

Decomposition:
- Package uart_pkg: register offsets (DATA 0x0, STATUS 0x4, CTRL 0x8, BAUD 0xC), STATUS/CTRL bit indices, TX/RX state enums.
- Sub-module uart_sync_fifo (params WIDTH, DEPTH): push/pop/flush, full/empty/level. Instantiated twice.
- TX, RX and register logic stay in uart_fifo.

Test Plan:
- Reset, then read 0x4 and 0xC -> 0x00000008 and 868; data_out_tx=1.
- BAUD_DIV=16, CTRL=0x2, write 0x55 to DATA -> line shows 0, 1,0,1,0,1,0,1,0, 1, each 16 clocks; tx_busy then tx_empty.
- Loop TX->RX, CTRL=0x3, write 0xA5, 0x3C -> two reads of 0x0 return 0xA5 then 0x3C; a third read returns 0 and rx_not_empty=0.
- Drive FIFO_DEPTH+1 chars into RX without reading -> rx_full=1, rx_overrun=1, first 16 chars intact; writing 0x20 to 0x4 clears overrun.
- Drive char with stop bit 0 -> rx_frame_err=1, FIFO empty, irq=1. Drive a 4-clock low glitch at div=16 -> nothing recorded.
- Queue 3 TX chars, write CTRL flush mid-second char -> line high next cycle, tx_empty=1, no further chars sent.
